// File: rtl/jkc_pkg.sv
// Shared opcodes, FSM states and helpers for the JK bank controller.
// Imported by jkc_jk_gen and jk_bank_ctrl.
package jkc_pkg;

   localparam logic [2:0] OP_NOP         = 3'd0;
   localparam logic [2:0] OP_LOAD        = 3'd1;
   localparam logic [2:0] OP_CLEAR       = 3'd2;
   localparam logic [2:0] OP_SET_MASK    = 3'd3;
   localparam logic [2:0] OP_TOGGLE_MASK = 3'd4;
   localparam logic [2:0] OP_COUNT_UP    = 3'd5;
   localparam logic [2:0] OP_COUNT_DN    = 3'd6;
   localparam logic [2:0] OP_SHIFT_L     = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Ops whose duration comes from cmd_len.
   function automatic logic is_multi(input logic [2:0] op);
      return (op == OP_COUNT_UP) ||
             (op == OP_COUNT_DN) ||
             (op == OP_SHIFT_L);
   endfunction

endpackage

// File: rtl/jkc_jk_gen.sv
// Combinational J/K pattern generator: (op, data, q, ser_in) -> (j, k).
// Ports: op, data[W], q[W], ser_in in; j[W], k[W] out.
module jkc_jk_gen
   import jkc_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [2:0]   op,
   input  logic [W-1:0] data,
   input  logic [W-1:0] q,
   input  logic         ser_in,
   output logic [W-1:0] j,
   output logic [W-1:0] k
);

   // Toggle enables: bit i flips when all lower bits are 1 (up) or 0 (down).
   logic [W-1:0] up_t;
   logic [W-1:0] dn_t;
   logic [W-1:0] shl;

   always_comb begin
      logic cu;
      logic cd;
      cu = 1'b1;
      cd = 1'b1;
      up_t = '0;
      dn_t = '0;
      for (int i = 0; i < W; i++) begin
         up_t[i] = cu;
         dn_t[i] = cd;
         cu = cu & q[i];
         cd = cd & ~q[i];
      end
   end

   assign shl = {q[W-2:0], ser_in};

   always_comb begin
      j = '0;
      k = '0;
      unique case (op)
         OP_LOAD: begin
            j = data;
            k = ~data;
         end
         OP_CLEAR: begin
            j = '0;
            k = '1;
         end
         OP_SET_MASK: begin
            j = data;
            k = '0;
         end
         OP_TOGGLE_MASK: begin
            j = data;
            k = data;
         end
         OP_COUNT_UP: begin
            j = up_t;
            k = up_t;
         end
         OP_COUNT_DN: begin
            j = dn_t;
            k = dn_t;
         end
         OP_SHIFT_L: begin
            j = shl;
            k = ~shl;
         end
         default: begin
            j = '0;
            k = '0;
         end
      endcase
   end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command sequencer for a W-bit JK flop bank (IDLE/EXEC/DONE FSM).
// Ports: clk, reset_n (async low); cmd_valid/ready/op/data/len handshake;
//   ser_in, abort, q_in in; j_out, k_out, busy, done, aborted out.
// Optional JKC_READBACK_EN adds rsp_data[W]/rsp_valid readback of q_in.
module jk_bank_ctrl
   import jkc_pkg::*;
#(
   parameter int W     = 4,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [W-1:0]     cmd_data,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             ser_in,
   input  logic             abort,
   input  logic [W-1:0]     q_in,
   output logic [W-1:0]     j_out,
   output logic [W-1:0]     k_out,
   output logic             busy,
   output logic             done,
`ifdef JKC_READBACK_EN
   output logic [W-1:0]     rsp_data,
   output logic             rsp_valid,
`endif
   output logic             aborted
);

   localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

   state_t           state_q;
   state_t           state_d;
   logic [2:0]       op_q;
   logic [W-1:0]     data_q;
   logic [LEN_W-1:0] cnt_q;
   logic             ab_q;
   logic [W-1:0]     gen_j;
   logic [W-1:0]     gen_k;
   logic             hs;

   jkc_jk_gen #(.W(W)) u_gen (
      .op     (op_q),
      .data   (data_q),
      .q      (q_in),
      .ser_in (ser_in),
      .j      (gen_j),
      .k      (gen_k)
   );

   assign hs = cmd_valid & cmd_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         op_q    <= OP_NOP;
         data_q  <= '0;
         cnt_q   <= '0;
         ab_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (hs) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            ab_q   <= 1'b0;
            if (is_multi(cmd_op) && cmd_len != '0)
               cnt_q <= cmd_len;
            else
               cnt_q <= ONE;
         end else if (state_q == ST_EXEC) begin
            cnt_q <= cnt_q - ONE;
            if (abort)
               ab_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      aborted   = 1'b0;
      j_out     = '0;
      k_out     = '0;
      unique case (state_q)
         ST_IDLE: begin
            // Ready is gated by reset_n so it is low throughout reset.
            cmd_ready = reset_n;
            if (cmd_valid && reset_n)
               state_d = (cmd_op == OP_NOP) ? ST_DONE : ST_EXEC;
         end
         ST_EXEC: begin
            busy = 1'b1;
            if (abort) begin
               // Suppress this cycle's bank update, even on the last step.
               state_d = ST_DONE;
            end else begin
               j_out = gen_j;
               k_out = gen_k;
               if (cnt_q == ONE)
                  state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            aborted = ab_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef JKC_READBACK_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_data  <= '0;
         rsp_valid <= 1'b0;
      end else begin
         rsp_valid <= (state_q == ST_DONE);
         if (state_q == ST_DONE)
            rsp_data <= q_in;
      end
   end
`endif

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Self-checking bench for jk_bank_ctrl with a behavioural JK bank.
// Reference model tracks the bank value with plain arithmetic per command.
module tb_jk_bank_ctrl;

   localparam int W     = 4;
   localparam int LEN_W = 8;

   localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, CLEAR = 3'd2,
      SETM = 3'd3, TOGM = 3'd4, CUP = 3'd5, CDN = 3'd6, SHL = 3'd7;

   logic             clk;
   logic             reset_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [W-1:0]     cmd_data;
   logic [LEN_W-1:0] cmd_len;
   logic             ser_in;
   logic             abort;
   logic [W-1:0]     q_bank;
   logic [W-1:0]     j_out;
   logic [W-1:0]     k_out;
   logic             busy;
   logic             done;
   logic             aborted;
`ifdef JKC_READBACK_EN
   logic [W-1:0]     rsp_data;
   logic             rsp_valid;
`endif

   int checks;
   int errors;
   logic [W-1:0] mq;

   jk_bank_ctrl #(.W(W), .LEN_W(LEN_W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_len   (cmd_len),
      .ser_in    (ser_in),
      .abort     (abort),
      .q_in      (q_bank),
      .j_out     (j_out),
      .k_out     (k_out),
      .busy      (busy),
      .done      (done),
`ifdef JKC_READBACK_EN
      .rsp_data  (rsp_data),
      .rsp_valid (rsp_valid),
`endif
      .aborted   (aborted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The JK flop bank, sharing clk/reset_n with the controller.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         q_bank <= '0;
      else
         for (int i = 0; i < W; i++)
            case ({j_out[i], k_out[i]})
               2'b10:   q_bank[i] <= 1'b1;
               2'b01:   q_bank[i] <= 1'b0;
               2'b11:   q_bank[i] <= ~q_bank[i];
               default: q_bank[i] <= q_bank[i];
            endcase
   end

   // Effect of one step of an op on the bank value.
   function automatic logic [W-1:0] step_q(input logic [2:0] op,
      input logic [W-1:0] d, input logic [W-1:0] q, input logic s);
      case (op)
         LOAD:    return d;
         CLEAR:   return '0;
         SETM:    return q | d;
         TOGM:    return q ^ d;
         CUP:     return q + 1'b1;
         CDN:     return q - 1'b1;
         SHL:     return {q[W-2:0], s};
         default: return q;
      endcase
   endfunction

   function automatic int steps_of(input logic [2:0] op,
      input logic [LEN_W-1:0] len);
      if (op == NOP) return 0;
      if (op >= CUP) return (len == 0) ? 1 : int'(len);
      return 1;
   endfunction

   task automatic wait_ready(input string nm);
      int t;
      t = 0;
      while (cmd_ready !== 1'b1 && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_timeout cmd_ready=%b want 1", nm, cmd_ready);
      end
   endtask

   task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] d,
      input logic [LEN_W-1:0] len, input logic [15:0] ser,
      input int abort_at, input string nm);
      int n;
      logic [W-1:0] exp;
      logic exp_ab;
      exp = mq;
      exp_ab = 1'b0;
      n = steps_of(op, len);
      wait_ready(nm);
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_data = d;
      cmd_len = len;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int s = 1; s <= n; s++) begin
         checks++;
         if (busy !== 1'b1 || cmd_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s exec_step%0d busy=%b rdy=%b done=%b want 1/0/0",
               nm, s, busy, cmd_ready, done);
         end
         ser_in = ser[(s-1)%16];
         abort = (s == abort_at);
         @(posedge clk); #1;
         if (s == abort_at) begin
            exp_ab = 1'b1;
            abort = 1'b0;
            break;
         end
         exp = step_q(op, d, exp, ser[(s-1)%16]);
      end
      abort = 1'b0;
      checks++;
      if (done !== 1'b1 || aborted !== exp_ab || busy !== 1'b0 ||
          cmd_ready !== 1'b0 || j_out !== '0 || k_out !== '0) begin
         errors++;
         $display("FAIL %s done_cycle done=%b ab=%b busy=%b rdy=%b j=%b k=%b want 1/%b/0/0/0/0",
            nm, done, aborted, busy, cmd_ready, j_out, k_out, exp_ab);
      end
      checks++;
      if (q_bank !== exp) begin
         errors++;
         $display("FAIL %s q=%b want %b", nm, q_bank, exp);
      end
      mq = exp;
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || cmd_ready !== 1'b1 || aborted !== 1'b0) begin
         errors++;
         $display("FAIL %s after_done done=%b rdy=%b ab=%b want 0/1/0",
            nm, done, cmd_ready, aborted);
      end
`ifdef JKC_READBACK_EN
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp) begin
         errors++;
         $display("FAIL %s rsp valid=%b data=%b want 1/%b",
            nm, rsp_valid, rsp_data, exp);
      end
`endif
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_op = NOP;
      cmd_data = '0;
      cmd_len = '0;
      ser_in = 1'b0;
      abort = 1'b0;
      #1;
      checks++;
      if (cmd_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          aborted !== 1'b0 || j_out !== '0 || k_out !== '0) begin
         errors++;
         $display("FAIL reset_hold rdy=%b busy=%b done=%b ab=%b j=%b k=%b want all 0",
            cmd_ready, busy, done, aborted, j_out, k_out);
      end
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      mq = '0;
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || q_bank !== '0) begin
         errors++;
         $display("FAIL reset_release rdy=%b busy=%b q=%b want 1/0/0000",
            cmd_ready, busy, q_bank);
      end
`ifdef JKC_READBACK_EN
      checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== '0) begin
         errors++;
         $display("FAIL reset_rsp valid=%b data=%b want 0/0000",
            rsp_valid, rsp_data);
      end
`endif
   endtask

   task automatic test_load();
      run_cmd(LOAD, 4'b1010, 8'd0, 16'h0, 0, "load_1010");
   endtask

   task automatic test_count_up_wrap();
      run_cmd(LOAD, 4'b1110, 8'd0, 16'h0, 0, "load_1110");
      run_cmd(CUP, 4'b0000, 8'd3, 16'h0, 0, "count_up3_wrap");
   endtask

   task automatic test_count_dn_toggle();
      run_cmd(CDN, 4'b0000, 8'd2, 16'h0, 0, "count_dn2_wrap");
      run_cmd(TOGM, 4'b0101, 8'd0, 16'h0, 0, "toggle_0101");
   endtask

   task automatic test_shift_abort();
      run_cmd(CLEAR, 4'b0000, 8'd0, 16'h0, 0, "clear");
      run_cmd(SHL, 4'b0000, 8'd4, 16'b1101, 0, "shift4_1011");
      run_cmd(SHL, 4'b0000, 8'd4, 16'b1101, 3, "shift4_abort3");
      run_cmd(CUP, 4'b0000, 8'd1, 16'h0, 1, "abort_last_step");
   endtask

   task automatic test_busy_hold();
      wait_ready("busy_hold");
      cmd_valid = 1'b1;
      cmd_op = CUP;
      cmd_data = '0;
      cmd_len = 8'd4;
      @(posedge clk); #1;
      cmd_op = LOAD;
      cmd_data = 4'b1111;
      for (int s = 0; s < 4; s++) begin
         checks++;
         if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_hold step%0d rdy=%b busy=%b want 0/1",
               s, cmd_ready, busy);
         end
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      mq = mq + 4'd4;
      checks++;
      if (done !== 1'b1 || q_bank !== mq) begin
         errors++;
         $display("FAIL busy_hold_done done=%b q=%b want 1/%b",
            done, q_bank, mq);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      wait_ready("reset_mid");
      cmd_valid = 1'b1;
      cmd_op = CUP;
      cmd_len = 8'd10;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if (j_out !== '0 || k_out !== '0 || busy !== 1'b0 ||
          done !== 1'b0 || cmd_ready !== 1'b0 || q_bank !== '0) begin
         errors++;
         $display("FAIL reset_mid j=%b k=%b busy=%b done=%b rdy=%b q=%b want all 0",
            j_out, k_out, busy, done, cmd_ready, q_bank);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      mq = '0;
      @(posedge clk); #1;
      run_cmd(LOAD, 4'b0011, 8'd0, 16'h0, 0, "after_reset_load");
   endtask

   task automatic test_nop();
      run_cmd(NOP, 4'b1111, 8'd5, 16'h0, 0, "nop");
   endtask

`ifdef JKC_READBACK_EN
   task automatic test_readback();
      run_cmd(LOAD, 4'b0110, 8'd0, 16'h0, 0, "rb_load_0110");
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== 4'b0110) begin
         errors++;
         $display("FAIL rb_hold valid=%b data=%b want 0/0110",
            rsp_valid, rsp_data);
      end
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         logic [2:0] op;
         logic [W-1:0] d;
         logic [LEN_W-1:0] len;
         int ab;
         op = 3'($urandom_range(0, 7));
         d = W'($urandom);
         len = LEN_W'($urandom_range(0, 5));
         ab = 0;
         if (op != NOP && $urandom_range(0, 3) == 0)
            ab = $urandom_range(1, steps_of(op, len));
         run_cmd(op, d, len, 16'($urandom), ab, "random");
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      mq = '0;
      test_reset();
      test_load();
      test_count_up_wrap();
      test_count_dn_toggle();
      test_shift_abort();
      test_busy_hold();
      test_reset_mid();
      test_nop();
`ifdef JKC_READBACK_EN
      test_readback();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
